// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: opcode encodings,
// field widths and the sequencer state type.
package alu_pkg;

    localparam int OPW    = 3;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_MUL = 3'd2;
    localparam logic [OPW-1:0] OP_DIV = 3'd3;
    localparam logic [OPW-1:0] OP_EXP = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Opcodes above EXP have no ALU strobe behind them.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        return (op <= OP_EXP);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Operand/opcode sequencer in front of the combinational 8-bit signed ALU.
// Latches A/B from DIN, drives one opcode strobe for SETTLE_CYCLES cycles,
// then captures ALU_R/ALU_OVF and pulses DONE.
// Optional build macro: DIV_ZERO_GUARD_EN rejects DIV with B == 0 as an error.
//
// state | meaning
// IDLE  | operands loadable, waiting for GO
// DRIVE | operands and one strobe held for the settle window
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DIN,
    input  logic              LOAD_A,
    input  logic              LOAD_B,
    input  logic [OPW-1:0]    OP,
    input  logic              GO,
    input  logic [RES_W-1:0]  ALU_R,
    input  logic              ALU_OVF,
    output logic [DATA_W-1:0] A_OUT,
    output logic [DATA_W-1:0] B_OUT,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV,
    output logic              EXP,
    output logic [RES_W-1:0]  RES,
    output logic              RES_OVF,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   b_next;
    logic [OPW-1:0]      op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RES_W-1:0]    res_q;
    logic                ovf_q, done_q, err_q;
    logic                go_ok, start, reject, capture;

    // A load in the GO cycle must be visible to the guard check.
    assign b_next = LOAD_B ? DIN : b_q;

`ifdef DIV_ZERO_GUARD_EN
    assign go_ok = op_legal(OP) && !((OP == OP_DIV) && (b_next == '0));
`else
    assign go_ok = op_legal(OP);
`endif

    // Next-state decode: accept or reject GO in IDLE, leave DRIVE on terminal count.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (GO) begin
                    if (go_ok) begin
                        start   = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand, opcode, settle down-counter, result and status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= capture | reject;
            if (state_q == IDLE) begin
                if (LOAD_A) a_q <= DIN;
                if (LOAD_B) b_q <= DIN;
            end
            if (start) begin
                op_q  <= OP;
                err_q <= 1'b0;
                cnt_q <= CNT_LAST;
            end else if ((state_q == DRIVE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (reject) err_q <= 1'b1;
            if (capture) begin
                res_q <= ALU_R;
                ovf_q <= ALU_OVF;
            end
        end
    end

    // One-hot strobe decode; everything low outside DRIVE so reset kills it at once.
    always_comb begin
        ADD = 1'b0;
        SUB = 1'b0;
        MUL = 1'b0;
        DIV = 1'b0;
        EXP = 1'b0;
        if (state_q == DRIVE) begin
            case (op_q)
                OP_ADD:  ADD = 1'b1;
                OP_SUB:  SUB = 1'b1;
                OP_MUL:  MUL = 1'b1;
                OP_DIV:  DIV = 1'b1;
                OP_EXP:  EXP = 1'b1;
                default: ;
            endcase
        end
    end

    assign A_OUT   = a_q;
    assign B_OUT   = b_q;
    assign RES     = res_q;
    assign RES_OVF = ovf_q;
    assign BUSY    = (state_q == DRIVE);
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream control stage for the 8-bit signed ALU. It latches two operands from a shared 8-bit data bus and drives them, with exactly one opcode line, onto the ALU's K/M inputs and its ADD/SUB/MUL/DIV/EXP strobes. It holds them stable for a settle window, then registers the ALU's 16-bit result and OVF and reports completion with a DONE pulse. It sits between the keypad/bus front end and the combinational ALU, and it also owns the result register.

Parameters:
SETTLE_CYCLES, 2, number of cycles operands and opcode are held before capture; legal range >= 1
OPW, 3, opcode field width

Ports:
CLK  in  1  single system clock, rising edge
RST_N  in  1  asynchronous, active-low reset
DIN  in  8  operand data bus
LOAD_A  in  1  load DIN into operand A register
LOAD_B  in  1  load DIN into operand B register
OP  in  OPW  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 EXP, 5-7 illegal
GO  in  1  start request, sampled only in IDLE
ALU_R  in  16  result from ALU R15..R0
ALU_OVF  in  1  overflow from ALU
A_OUT  out  8  to ALU K7..K0
B_OUT  out  8  to ALU M7..M0
ADD, SUB, MUL, DIV, EXP  out  1 each  one-hot opcode strobes to ALU
RES  out  16  captured result
RES_OVF  out  1  captured overflow
BUSY  out  1  operation in progress
DONE  out  1  one-cycle completion pulse
ERR  out  1  error flag for the last operation

Behaviour:
- Reset (async, RST_N=0): all registers and outputs are 0, state is IDLE, and all strobes drop immediately, including mid-operation.
- A_OUT/B_OUT are the A/B registers, driven continuously.
- LOAD_A/LOAD_B are honoured only in IDLE. Both asserted together loads DIN into both registers. While BUSY they are ignored.
- FSM states: IDLE, DRIVE.
  - IDLE -> DRIVE on GO with a legal opcode. The opcode is latched at that edge.
  - LOAD and GO in the same cycle: the operation uses the newly loaded value.
- DRIVE:
  - Exactly one strobe matches the latched opcode; all others are 0.
  - BUSY=1.
  - The settle counter runs 0..SETTLE_CYCLES-1.
  - On the last DRIVE cycle edge: RES<=ALU_R, RES_OVF<=ALU_OVF, return to IDLE.
- Timing: with GO sampled at edge 0, the strobe is high for cycles 1..SETTLE_CYCLES. In cycle SETTLE_CYCLES+1, RES/RES_OVF are valid, DONE=1 and BUSY=0.
  - Back-to-back: GO may be accepted in the DONE cycle, giving a throughput of one operation per SETTLE_CYCLES+1 cycles.
- Illegal opcode on GO: no DRIVE and no strobe. Next cycle DONE=1 and ERR=1. RES/RES_OVF are unchanged.
- ERR holds until the next accepted GO, where it clears. RES holds until the next capture.
- GO while BUSY is ignored (not queued).
- DIV result layout is passed through unchanged: RES[15:8] = quotient, RES[7:0] = remainder.

Optional Feature:
Macro DIV_ZERO_GUARD_EN.
- Defined: GO with OP=DIV and B register == 0 is treated like an illegal opcode. No strobe; DONE+ERR next cycle; RES unchanged.
- Undefined: the division is issued normally and whatever ALU_R/ALU_OVF present is captured, with ERR=0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_EXP
  - OPW
  - the state enum {IDLE, DRIVE}
  - the result width constant (16)
- No sub-module. The settle counter and FSM are small enough to live in one module.

Test Plan:
- SETTLE_CYCLES=2; load A=5, B=3; GO with OP=0 -> ADD high in cycles 1-2; cycle 3: RES=0x0008, DONE=1, ERR=0.
- A=-3 (0xFD), B=4, OP=2 -> RES=0xFFF4, RES_OVF=0; the other four strobes are never high.
- A=7, B=2, OP=3 -> RES=0x0301.
- B=0, OP=3:
  - with DIV_ZERO_GUARD_EN: DONE+ERR at cycle 1, DIV never asserted, RES unchanged;
  - without: DIV asserted and ERR=0.
- OP=6 with GO -> DONE=1, ERR=1 next cycle, no strobe. A following legal GO clears ERR.
- Deassert RST_N during DRIVE with MUL high -> MUL drops asynchronously; RES=0, BUSY=0, DONE=0. LOAD_A and GO during BUSY are ignored (A_OUT unchanged).
